// File: rtl/i2c_master.sv
// i2c_master: single-byte I2C initiator on one system clock.
// START, address+R/W, one data byte with ACK checks, then STOP.
module i2c_master #(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    inout  wire        sda,
    inout  wire        scl
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ACK_A, WDATA, ACK_D, RDATA, MNACK, STOP
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] div_cnt;
    logic [1:0]    qtr;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg, wdata_r;
    logic          rw_r, smp;
    logic          accept, tick, bit_end, byte_last, in_byte;
    logic          sda_low, scl_low;

    assign accept    = start && !busy;
    assign tick      = busy && (div_cnt == CW'(DIV - 1));
    assign bit_end   = tick && (qtr == 2'd3);
    assign byte_last = (bit_cnt == 3'd0);
    assign in_byte   = (state == ADDR) || (state == WDATA) || (state == RDATA);

    assign sda = sda_low ? 1'b0 : 1'bz;
    assign scl = scl_low ? 1'b0 : 1'bz;

    always_comb begin
        state_n = state;
        sda_low = 1'b0;
        scl_low = 1'b0;
        unique case (state)
            IDLE: if (accept) state_n = START;
            START: begin
                sda_low = qtr[1];
                if (bit_end) state_n = ADDR;
            end
            ADDR: begin
                scl_low = !qtr[1];
                sda_low = !shreg[7];
                if (bit_end && byte_last) state_n = ACK_A;
            end
            ACK_A: begin
                scl_low = !qtr[1];
                if (bit_end) state_n = smp ? STOP : (rw_r ? RDATA : WDATA);
            end
            WDATA: begin
                scl_low = !qtr[1];
                sda_low = !shreg[7];
                if (bit_end && byte_last) state_n = ACK_D;
            end
            ACK_D: begin
                scl_low = !qtr[1];
                if (bit_end) state_n = STOP;
            end
            RDATA: begin
                scl_low = !qtr[1];
                if (bit_end && byte_last) state_n = MNACK;
            end
            MNACK: begin
                scl_low = !qtr[1];
                if (bit_end) state_n = STOP;
            end
            STOP: begin
                // sda rises in Q3 while scl is high
                scl_low = !qtr[1];
                sda_low = (qtr != 2'd3);
                if (bit_end) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            div_cnt <= '0;
            qtr     <= 2'd0;
            bit_cnt <= 3'd7;
            shreg   <= 8'h00;
            wdata_r <= 8'h00;
            rw_r    <= 1'b0;
            smp     <= 1'b1;
            rdata   <= 8'h00;
            busy    <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
        end else begin
            state <= state_n;
            done  <= 1'b0;
            if (accept) begin
                shreg   <= {addr, rw};
                wdata_r <= wdata;
                rw_r    <= rw;
                busy    <= 1'b1;
                ack_err <= 1'b0;
                div_cnt <= '0;
                qtr     <= 2'd0;
                bit_cnt <= 3'd7;
            end else if (busy) begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) qtr <= qtr + 2'd1;
                if (tick && qtr == 2'd2) begin
                    smp <= sda;
                    if (state == RDATA) rdata <= {rdata[6:0], sda};
                end
                if (bit_end) begin
                    bit_cnt <= in_byte ? bit_cnt - 3'd1 : 3'd7;
                    if (state == ADDR)
                        shreg <= byte_last ? wdata_r : {shreg[6:0], 1'b0};
                    if (state == WDATA) shreg <= {shreg[6:0], 1'b0};
                    if ((state == ACK_A || state == ACK_D) && smp)
                        ack_err <= 1'b1;
                    if (state == STOP) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: two buses (DIV=4 and DIV=1), each with a
// behavioural slave at address 0x55 that returns 0xCC on reads.
module tb_i2c_master;
    localparam int DIV0 = 4;
    localparam int DIV1 = 1;
    localparam logic [6:0] SLV_ADDR = 7'h55;
    localparam logic [7:0] SLV_TX = 8'hCC;
    localparam int K_DONE = 1;
    localparam int K_SNAP = 2;

    typedef struct {
        int         kind;
        int         bus;
        int         cyc;
        logic       ack_err;
        logic       chk_rd;
        logic [7:0] rdata;
        logic       chk_wr;
        logic [7:0] rx;
        int         pulses;
        logic       chk_mn;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0] rst_v, srst_v, start_v, rw_v;
    logic [6:0] addr_v [2];
    logic [7:0] wdata_v [2];
    logic [7:0] o_rdata [2];
    logic [1:0] o_busy, o_done, o_ack, o_sda, o_scl, o_mnack;
    logic [7:0] o_rx [2];
    int         o_pulses [2];

    exp_t q[$];
    exp_t mon_e;
    logic [1:0] snap_req;
    logic stim_done;
    int tmo;
    int checks = 0;
    int errors = 0;

    for (genvar b = 0; b < 2; b++) begin : g_bus
        wire sda_w, scl_w;
        logic s_drv = 1'b0;
        logic p_sda = 1'b1, p_scl = 1'b1;
        logic [7:0] sh = 8'h00, tsh = 8'h00, rx = 8'h00;
        logic rw_s = 1'b0, had_rise = 1'b0, mnack = 1'b0;
        int ss = 0, cnt = 0, pulses = 0, last_pulses = 0;

        pullup (sda_w);
        pullup (scl_w);
        assign sda_w = s_drv ? 1'b0 : 1'bz;

        i2c_master #(.DIV((b == 0) ? DIV0 : DIV1)) u_dut (
            .clk(clk), .rst(rst_v[b]), .start(start_v[b]),
            .addr(addr_v[b]), .rw(rw_v[b]), .wdata(wdata_v[b]),
            .rdata(o_rdata[b]), .busy(o_busy[b]), .done(o_done[b]),
            .ack_err(o_ack[b]), .sda(sda_w), .scl(scl_w)
        );

        assign o_sda[b] = sda_w;
        assign o_scl[b] = scl_w;
        assign o_rx[b] = rx;
        assign o_pulses[b] = last_pulses;
        assign o_mnack[b] = mnack;

        // ss: 0 idle, 1 addr, 2 addr ack, 3 write, 4 data ack,
        // 5 read, 6 master ack, 7 ignore until STOP
        always @(posedge clk) begin
            p_sda <= sda_w;
            p_scl <= scl_w;
            if (srst_v[b]) begin
                ss <= 0; s_drv <= 1'b0; rx <= 8'h00; cnt <= 0;
                last_pulses <= 0; mnack <= 1'b0; pulses <= 0;
            end else if (p_scl && scl_w && p_sda && !sda_w) begin
                ss <= 1; cnt <= 0; s_drv <= 1'b0; pulses <= 0;
                had_rise <= 1'b0; last_pulses <= 99; mnack <= 1'b0;
            end else if (p_scl && scl_w && !p_sda && sda_w) begin
                ss <= 0; s_drv <= 1'b0; last_pulses <= pulses;
            end else if (!p_scl && scl_w) begin
                had_rise <= 1'b1;
                if (ss == 1 || ss == 3) begin
                    sh <= {sh[6:0], sda_w};
                    cnt <= cnt + 1;
                end
                if (ss == 6) mnack <= sda_w;
            end else if (p_scl && !scl_w) begin
                if (had_rise) pulses <= pulses + 1;
                case (ss)
                    1: if (cnt == 8) begin
                        if (sh[7:1] == SLV_ADDR) begin
                            s_drv <= 1'b1; rw_s <= sh[0]; ss <= 2;
                        end else ss <= 7;
                    end
                    2: if (rw_s) begin
                        s_drv <= ~SLV_TX[7]; tsh <= SLV_TX << 1;
                        cnt <= 1; ss <= 5;
                    end else begin
                        s_drv <= 1'b0; cnt <= 0; ss <= 3;
                    end
                    3: if (cnt == 8) begin
                        rx <= sh; s_drv <= 1'b1; ss <= 4;
                    end
                    4: begin s_drv <= 1'b0; ss <= 7; end
                    5: if (cnt < 8) begin
                        s_drv <= ~tsh[7]; tsh <= tsh << 1; cnt <= cnt + 1;
                    end else begin
                        s_drv <= 1'b0; ss <= 6;
                    end
                    6: ss <= 7;
                    default: ;
                endcase
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (o_done[b]) begin
                chk($sformatf("bus%0d done_expected", b),
                    int'(q.size() > 0 && q[0].kind == K_DONE && q[0].bus == b), 1);
                if (q.size() > 0 && q[0].kind == K_DONE && q[0].bus == b) begin
                    mon_e = q.pop_front();
                    chk($sformatf("bus%0d done_cycle", b), cyc, mon_e.cyc);
                    chk($sformatf("bus%0d ack_err", b), int'(o_ack[b]), int'(mon_e.ack_err));
                    chk($sformatf("bus%0d busy_at_done", b), int'(o_busy[b]), 0);
                    chk($sformatf("bus%0d scl_pulses", b), o_pulses[b], mon_e.pulses);
                    if (mon_e.chk_rd)
                        chk($sformatf("bus%0d rdata", b), int'(o_rdata[b]), int'(mon_e.rdata));
                    if (mon_e.chk_wr)
                        chk($sformatf("bus%0d slave_rx", b), int'(o_rx[b]), int'(mon_e.rx));
                    if (mon_e.chk_mn)
                        chk($sformatf("bus%0d master_nack", b), int'(o_mnack[b]), 1);
                end
            end
            if (snap_req[b]) begin
                chk($sformatf("bus%0d snap_expected", b),
                    int'(q.size() > 0 && q[0].kind == K_SNAP && q[0].bus == b), 1);
                if (q.size() > 0 && q[0].kind == K_SNAP && q[0].bus == b) begin
                    mon_e = q.pop_front();
                    chk($sformatf("bus%0d snap_busy", b), int'(o_busy[b]), 0);
                    chk($sformatf("bus%0d snap_done", b), int'(o_done[b]), 0);
                    chk($sformatf("bus%0d snap_ack_err", b), int'(o_ack[b]), int'(mon_e.ack_err));
                    chk($sformatf("bus%0d snap_rdata", b), int'(o_rdata[b]), int'(mon_e.rdata));
                    chk($sformatf("bus%0d snap_sda", b), int'(o_sda[b]), 1);
                    chk($sformatf("bus%0d snap_scl", b), int'(o_scl[b]), 1);
                end
            end
        end
        if (stim_done) begin
            chk("leftover_expectations", q.size(), 0);
            chk("wait_timeouts", tmo, 0);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    task automatic push_done(input int b, input int c, input logic ae,
                             input logic cr, input logic [7:0] rd,
                             input logic cw, input logic [7:0] wr,
                             input int p, input logic mn);
        exp_t e;
        e.kind = K_DONE; e.bus = b; e.cyc = c; e.ack_err = ae;
        e.chk_rd = cr; e.rdata = rd; e.chk_wr = cw; e.rx = wr;
        e.pulses = p; e.chk_mn = mn;
        q.push_back(e);
    endtask

    task automatic push_snap(input int b, input logic ae, input logic [7:0] rd);
        exp_t e;
        e.kind = K_SNAP; e.bus = b; e.cyc = 0; e.ack_err = ae;
        e.chk_rd = 1'b1; e.rdata = rd; e.chk_wr = 1'b0; e.rx = 8'h00;
        e.pulses = 0; e.chk_mn = 1'b0;
        q.push_back(e);
    endtask

    task automatic snap(input int b, input logic ae, input logic [7:0] rd);
        push_snap(b, ae, rd);
        snap_req[b] = 1'b1;
        @(posedge clk); #1;
        snap_req[b] = 1'b0;
    endtask

    task automatic go(input int b, input logic [6:0] a, input logic r,
                      input logic [7:0] w, output int e);
        addr_v[b] = a; rw_v[b] = r; wdata_v[b] = w; start_v[b] = 1'b1;
        @(posedge clk); #1;
        e = cyc;
        start_v[b] = 1'b0;
    endtask

    task automatic wait_done(input int b);
        int n;
        n = 0;
        while (!o_done[b] && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 1000) tmo++;
        @(posedge clk); #1;
    endtask

    initial begin
        int e0;
        tmo = 0; stim_done = 1'b0; snap_req = 2'b00;
        rst_v = 2'b11; srst_v = 2'b11; start_v = 2'b00; rw_v = 2'b00;
        for (int i = 0; i < 2; i++) begin
            addr_v[i] = 7'h00; wdata_v[i] = 8'h00;
        end
        repeat (3) @(posedge clk); #1;
        push_snap(0, 1'b0, 8'h00);
        push_snap(1, 1'b0, 8'h00);
        snap_req = 2'b11;
        @(posedge clk); #1;
        snap_req = 2'b00; rst_v = 2'b00; srst_v = 2'b00;
        repeat (2) @(posedge clk); #1;

        go(0, 7'h55, 1'b0, 8'hA5, e0);
        push_done(0, e0 + 80 * DIV0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA5, 18, 1'b0);
        wait_done(0);

        go(0, 7'h55, 1'b1, 8'h00, e0);
        push_done(0, e0 + 80 * DIV0, 1'b0, 1'b1, 8'hCC, 1'b0, 8'h00, 18, 1'b1);
        wait_done(0);

        go(0, 7'h2A, 1'b0, 8'h77, e0);
        push_done(0, e0 + 44 * DIV0, 1'b1, 1'b1, 8'hCC, 1'b0, 8'h00, 9, 1'b0);
        wait_done(0);
        repeat (5) @(posedge clk); #1;
        snap(0, 1'b1, 8'hCC);

        addr_v[0] = 7'h55; rw_v[0] = 1'b0; wdata_v[0] = 8'h5A; start_v[0] = 1'b1;
        @(posedge clk); #1;
        e0 = cyc;
        push_done(0, e0 + 80 * DIV0, 1'b0, 1'b1, 8'hCC, 1'b1, 8'h5A, 18, 1'b0);
        for (int i = 0; i < 300; i++) begin
            addr_v[0] = 7'($urandom);
            rw_v[0] = 1'($urandom);
            wdata_v[0] = 8'($urandom);
            @(posedge clk); #1;
        end
        start_v[0] = 1'b0;
        wait_done(0);
        repeat (20) @(posedge clk); #1;
        snap(0, 1'b0, 8'hCC);

        go(0, 7'h55, 1'b0, 8'hF0, e0);
        while (cyc < e0 + 50 * DIV0) begin @(posedge clk); #1; end
        rst_v[0] = 1'b1; srst_v[0] = 1'b1;
        @(posedge clk); #1;
        rst_v[0] = 1'b0; srst_v[0] = 1'b0;
        snap(0, 1'b0, 8'h00);
        repeat (400) @(posedge clk); #1;
        go(0, 7'h55, 1'b0, 8'h3C, e0);
        push_done(0, e0 + 80 * DIV0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h3C, 18, 1'b0);
        wait_done(0);

        go(1, 7'h55, 1'b0, 8'h96, e0);
        push_done(1, e0 + 80 * DIV1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h96, 18, 1'b0);
        while (cyc < e0 + 40) begin @(posedge clk); #1; end
        addr_v[1] = 7'h55; rw_v[1] = 1'b1; wdata_v[1] = 8'h00; start_v[1] = 1'b1;
        while (cyc < e0 + 80 * DIV1 + 1) begin @(posedge clk); #1; end
        start_v[1] = 1'b0;
        push_done(1, e0 + 160 * DIV1 + 1, 1'b0, 1'b1, 8'hCC, 1'b0, 8'h00, 18, 1'b1);
        wait_done(1);

        repeat (10) @(posedge clk); #1;
        stim_done = 1'b1;
    end
endmodule
